// File: rtl/board_io_pkg.sv
// Shared types and width helpers for the board input conditioner.
// Events carry a channel field wide enough for the largest supported board (32 inputs).
package board_io_pkg;

  localparam int MAX_CH = 32;
  localparam int CH_W   = $clog2(MAX_CH);

  typedef struct packed {
    logic            rise;
    logic [CH_W-1:0] ch;
  } board_evt_t;

  // Index width that never collapses to zero bits for single-channel builds.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Debounce counter width: must hold DEBOUNCE_CYCLES-1 without wrapping.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/fpga_board_input_conditioner_fifo.sv
// Registered-output event FIFO (no fall-through); a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module fpga_board_input_conditioner_fifo
  import board_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  board_evt_t               data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output board_evt_t               data_o,
  output logic [$clog2(DEPTH):0]   usage_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [UW-1:0] usage_q;
  board_evt_t    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (usage_q == UW'(DEPTH));
  assign empty_o = (usage_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign usage_o = usage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   usage_q <= usage_q + 1'b1;
        2'b01:   usage_q <= usage_q - 1'b1;
        default: usage_q <= usage_q;
      endcase
    end
  end

endmodule

// File: rtl/fpga_board_input_conditioner.sv
// Synchronises, optionally inverts and debounces raw board inputs, then queues
// per-channel edge events into a small FIFO for polling or interrupt use.
module fpga_board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int N_CH            = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [N_CH-1:0]                  pad_i,
  input  logic [N_CH-1:0]                  en_i,
  input  logic [N_CH-1:0]                  invert_i,
  output logic [N_CH-1:0]                  level_o,
  output logic [N_CH-1:0]                  rise_o,
  output logic [N_CH-1:0]                  fall_o,
  output logic                             evt_valid_o,
  input  logic                             evt_ready_i,
  output logic [idx_width(N_CH)-1:0]       evt_ch_o,
  output logic                             evt_rise_o,
  output logic [$clog2(FIFO_DEPTH):0]      evt_usage_o,
  output logic                             evt_overflow_o,
  input  logic                             clr_overflow_i
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int EW    = idx_width(N_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] flip, pend_q, pdir_q, grant_oh;
  logic [CH_W-1:0] grant_idx;
  logic            grant_dir, any_pend, fifo_push, fifo_full, fifo_empty, evt_pop, ovf_q;
  board_evt_t      push_evt, head_evt;
  logic            unused_head_bits;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q, rise_q, fall_q, s, flip_c;

    assign s      = sync_q[SYNC_STAGES-1] ^ invert_i[c];
    // Saturating compare so an out-of-range count can never skip the flip point.
    assign flip_c = en_i[c] && (s != level_q) && (cnt_q >= CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i[c]};
        rise_q <= flip_c & ~level_q;
        fall_q <= flip_c & level_q;
        if (!en_i[c] || (s == level_q)) begin
          cnt_q <= '0;
        end else if (flip_c) begin
          cnt_q   <= '0;
          level_q <= ~level_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign flip[c]    = flip_c;
    assign level_o[c] = level_q;
    assign rise_o[c]  = rise_q;
    assign fall_o[c]  = fall_q;
  end

  // Lowest pending channel wins; scanning downward leaves the smallest index last.
  always_comb begin
    grant_idx = '0;
    grant_dir = 1'b0;
    grant_oh  = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (pend_q[c]) begin
        grant_idx   = c[CH_W-1:0];
        grant_dir   = pdir_q[c];
        grant_oh    = '0;
        grant_oh[c] = 1'b1;
      end
    end
  end

  assign any_pend       = |pend_q;
  assign evt_pop        = evt_valid_o & evt_ready_i;
  assign fifo_push      = any_pend & (~fifo_full | evt_pop);
  assign push_evt.rise  = grant_dir;
  assign push_evt.ch    = grant_idx;

  // A flip landing on a still-pending channel is lost; a fresh flip is never merged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      pdir_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (flip[c] && !pend_q[c]) begin
          pend_q[c] <= 1'b1;
          pdir_q[c] <= ~level_o[c];
        end else if (fifo_push && grant_oh[c]) begin
          pend_q[c] <= 1'b0;
        end
      end
      if (|(flip & pend_q))  ovf_q <= 1'b1;
      else if (clr_overflow_i) ovf_q <= 1'b0;
    end
  end

  fpga_board_input_conditioner_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (push_evt),
    .pop_i   (evt_ready_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (head_evt),
    .usage_o (evt_usage_o)
  );

  assign evt_valid_o      = ~fifo_empty;
  assign evt_ch_o         = head_evt.ch[EW-1:0];
  assign evt_rise_o       = head_evt.rise;
  assign evt_overflow_o   = ovf_q;
  assign unused_head_bits = ^head_evt.ch;

endmodule

// File: tb/tb_fpga_board_input_conditioner.sv
// Randomised and directed bench for the board input conditioner; a window-based
// reference model predicts levels and events, a monitor scores the DUT output.
module tb_fpga_board_input_conditioner;

  localparam int N     = 8;
  localparam int SS    = 2;
  localparam int DEB   = 4;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pad_i = '0, en_i = '1, invert_i = '0;
  logic [N-1:0] level_o, rise_o, fall_o;
  logic         evt_valid_o, evt_ready_i = 1'b0, evt_rise_o, evt_overflow_o;
  logic         clr_overflow_i = 1'b0;
  logic [2:0]   evt_ch_o;
  logic [1:0]   evt_usage_o;

  int checks_n = 0;
  int errors_n = 0;

  typedef struct { int ch; bit rise; } ev_t;

  logic [N-1:0]   m_level = '0, m_rise = '0, m_fall = '0, m_pend = '0, m_pdir = '0;
  bit             m_ovf = 1'b0;
  logic [DEB-1:0] m_win [N];
  logic [N-1:0]   m_pad_hist [$];
  ev_t            m_fifo [$];
  ev_t            exp_q [$];

  fpga_board_input_conditioner #(
    .N_CH            (N),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DEB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pad_i          (pad_i),
    .en_i           (en_i),
    .invert_i       (invert_i),
    .level_o        (level_o),
    .rise_o         (rise_o),
    .fall_o         (fall_o),
    .evt_valid_o    (evt_valid_o),
    .evt_ready_i    (evt_ready_i),
    .evt_ch_o       (evt_ch_o),
    .evt_rise_o     (evt_rise_o),
    .evt_usage_o    (evt_usage_o),
    .evt_overflow_o (evt_overflow_o),
    .clr_overflow_i (clr_overflow_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_n++;
    if (actual !== expected) begin
      errors_n++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Level flips once the last DEB cycles all saw an enabled input differing from it.
  task automatic modelStep();
    logic [N-1:0] sync_out, s, flips, old_pend;
    bit pop, room, drop;
    ev_t ev;
    sync_out = (m_pad_hist.size() >= SS) ? m_pad_hist[SS-1] : '0;
    m_pad_hist.push_front(pad_i);
    if (m_pad_hist.size() > SS) void'(m_pad_hist.pop_back());
    s        = sync_out ^ invert_i;
    old_pend = m_pend;
    pop      = (m_fifo.size() > 0) && evt_ready_i;
    room     = (m_fifo.size() < DEPTH) || pop;
    if (pop) void'(m_fifo.pop_front());
    if (room && (m_pend != '0)) begin
      for (int c = 0; c < N; c++) begin
        if (m_pend[c]) begin
          ev.ch = c; ev.rise = m_pdir[c];
          m_fifo.push_back(ev);
          exp_q.push_back(ev);
          m_pend[c] = 1'b0;
          break;
        end
      end
    end
    flips = '0;
    for (int c = 0; c < N; c++) begin
      if (!en_i[c]) m_win[c] = '0;
      else begin
        m_win[c] = {m_win[c][DEB-2:0], s[c] != m_level[c]};
        if (&m_win[c]) begin
          flips[c]   = 1'b1;
          m_level[c] = s[c];
          m_win[c]   = '0;
        end
      end
    end
    m_rise = flips & m_level;
    m_fall = flips & ~m_level;
    drop = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (flips[c]) begin
        if (old_pend[c]) drop = 1'b1;
        else begin m_pend[c] = 1'b1; m_pdir[c] = m_level[c]; end
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_overflow_i) m_ovf = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_pdir = '0; m_ovf = 1'b0;
      for (int c = 0; c < N; c++) m_win[c] = '0;
      m_pad_hist.delete();
      m_fifo.delete();
      exp_q.delete();
    end else begin
      modelStep();
    end
  end

  // Monitor: per-cycle output comparison plus scoreboard pop on each handshake.
  always @(negedge clk) begin
    ev_t ev;
    if (rst_n) begin
      checkOutput("level_o", 32'(level_o), 32'(m_level));
      checkOutput("rise_o", 32'(rise_o), 32'(m_rise));
      checkOutput("fall_o", 32'(fall_o), 32'(m_fall));
      checkOutput("evt_valid_o", 32'(evt_valid_o), 32'(m_fifo.size() != 0));
      checkOutput("evt_usage_o", 32'(evt_usage_o), 32'(m_fifo.size()));
      checkOutput("evt_overflow_o", 32'(evt_overflow_o), 32'(m_ovf));
      if (evt_valid_o && evt_ready_i) begin
        if (exp_q.size() == 0) begin
          checks_n++;
          errors_n++;
          $display("[TB] FAIL evt_unexpected actual ch=%0d rise=%0d expected none", evt_ch_o, evt_rise_o);
        end else begin
          ev = exp_q.pop_front();
          checkOutput("evt_ch_o", 32'(evt_ch_o), 32'(ev.ch));
          checkOutput("evt_rise_o", 32'(evt_rise_o), 32'(ev.rise));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] pad, input logic [N-1:0] en,
                               input logic [N-1:0] inv, input logic ready, input logic clr);
    tick();
    pad_i = pad; en_i = en; invert_i = inv; evt_ready_i = ready; clr_overflow_i = clr;
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    pad_i = '0; en_i = '1; invert_i = '0; evt_ready_i = 1'b0; clr_overflow_i = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int got [$];
    logic [N-1:0] p;
    for (int c = 0; c < N; c++) m_win[c] = '0;
    $display("[TB] start");

    // Reset state
    doReset();
    tick();
    checkOutput("rst_level", 32'(level_o), 32'h0);
    checkOutput("rst_valid", 32'(evt_valid_o), 32'h0);
    checkOutput("rst_usage", 32'(evt_usage_o), 32'h0);
    checkOutput("rst_pulses", 32'({rise_o, fall_o}), 32'h0);

    // ch0 held high: level at edge 6, rise pulse one cycle, event at edge 7
    applyStimulus(8'h01, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick(5);
    checkOutput("t2_level_e5", 32'(level_o[0]), 32'h0);
    tick();
    checkOutput("t2_level_e6", 32'(level_o[0]), 32'h1);
    checkOutput("t2_rise_e6", 32'(rise_o[0]), 32'h1);
    checkOutput("t2_valid_e6", 32'(evt_valid_o), 32'h0);
    tick();
    checkOutput("t2_rise_e7", 32'(rise_o[0]), 32'h0);
    checkOutput("t2_valid_e7", 32'(evt_valid_o), 32'h1);
    checkOutput("t2_ch_e7", 32'(evt_ch_o), 32'h0);
    checkOutput("t2_dir_e7", 32'(evt_rise_o), 32'h1);
    evt_ready_i = 1'b1;
    tick(4);
    pad_i = '0;
    tick(12);

    // ch3 glitch shorter than the debounce window
    pad_i = 8'h08;
    tick(3);
    pad_i = 8'h00;
    tick(10);
    checkOutput("t3_level", 32'(level_o[3]), 32'h0);
    checkOutput("t3_valid", 32'(evt_valid_o), 32'h0);

    // ch1, ch5, ch2 flip together; priority order on pop
    evt_ready_i = 1'b0;
    pad_i = 8'h26;
    tick(8);
    checkOutput("t4_usage_full", 32'(evt_usage_o), 32'h2);
    evt_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (evt_valid_o && evt_ready_i) got.push_back(int'(evt_ch_o));
      tick();
    end
    checkOutput("t4_count", 32'(got.size()), 32'h3);
    if (got.size() == 3) begin
      checkOutput("t4_first", 32'(got[0]), 32'h1);
      checkOutput("t4_second", 32'(got[1]), 32'h2);
      checkOutput("t4_third", 32'(got[2]), 32'h5);
    end
    pad_i = '0;
    tick(12);

    // Backpressure with FIFO full, then a drop on a pending channel
    doReset();
    applyStimulus(8'h0E, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick(9);
    checkOutput("t5_usage", 32'(evt_usage_o), 32'h2);
    checkOutput("t5_ovf_clear", 32'(evt_overflow_o), 32'h0);
    pad_i = 8'h06;
    tick(8);
    checkOutput("t5_ovf_set", 32'(evt_overflow_o), 32'h1);
    checkOutput("t5_usage_held", 32'(evt_usage_o), 32'h2);
    clr_overflow_i = 1'b1;
    tick();
    clr_overflow_i = 1'b0;
    checkOutput("t5_ovf_cleared", 32'(evt_overflow_o), 32'h0);
    evt_ready_i = 1'b1;
    tick(8);

    // Inverted channel and disabled channel produce no events
    pad_i = 8'h16; invert_i = 8'h10;
    tick(10);
    checkOutput("t6_inv_level", 32'(level_o[4]), 32'h0);
    checkOutput("t6_inv_valid", 32'(evt_valid_o), 32'h0);
    en_i = 8'hEF; pad_i = 8'h06;
    tick(10);
    checkOutput("t6_en_level", 32'(level_o[4]), 32'h0);
    checkOutput("t6_en_valid", 32'(evt_valid_o), 32'h0);
    en_i = 8'hFF;
    tick(10);

    // Asynchronous reset in the middle of a count
    pad_i = 8'h46;
    tick(3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_level", 32'(level_o), 32'h0);
    checkOutput("t6_rst_usage", 32'(evt_usage_o), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(10);

    // Random traffic; second half starves the reader to force overflows
    for (int cyc = 0; cyc < 3000; cyc++) begin
      p = pad_i;
      for (int c = 0; c < N; c++) if ($urandom_range(0, 23) == 0) p[c] = ~p[c];
      pad_i = p;
      if ($urandom_range(0, 199) == 0) en_i[$urandom_range(0, N - 1)] = 1'b0;
      if ($urandom_range(0, 59) == 0)  en_i[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 299) == 0) invert_i[$urandom_range(0, N - 1)] ^= 1'b1;
      evt_ready_i    = (cyc < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr_overflow_i = ($urandom_range(0, 63) == 0);
      tick();
    end

    clr_overflow_i = 1'b0;
    evt_ready_i = 1'b1;
    tick(40);
    checkOutput("drain_scoreboard", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
